neocore_core_top: RTL and testbench
===================================

// Module: neocore_core_top
// PURPOSE
//  Minimal in-order, single-issue NeoCore execution core for bring-up.
//  - Fetches 16-bit big-endian instructions over a 128-bit fetch port of the unified memory.
//  - Executes NOP/HLT and drives status outputs: halted, current_pc, dual_issue_active.
//  - Sits between the SoC top and unified_memory; the data port is present but reserved in this revision.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  ADDR_WIDTH  32             width of mem_if_addr / mem_data_addr
// PORTS
//  clk                input   1    clock, all logic on posedge
//  rst                input   1    reset, synchronous, active-high
//  mem_if_addr        output  32   fetch address (= PC)
//  mem_if_req         output  1    fetch request, held until mem_if_ack
//  mem_if_rdata       input   128  16 bytes from mem_if_addr; byte[addr] in [127:120]
//  mem_if_ack         input   1    fetch data valid, one-cycle pulse
//  mem_data_addr      output  32   data address (reserved, driven 0)
//  mem_data_wdata     output  32   store data (reserved, driven 0)
//  mem_data_size      output  2    access size (reserved, driven 0)
//  mem_data_we        output  1    write enable (reserved, driven 0)
//  mem_data_req       output  1    data request (reserved, driven 0)
//  mem_data_rdata     input   32   load data (ignored)
//  mem_data_ack       input   1    data ack (ignored)
//  halted             output  1    sticky: HLT executed
//  current_pc         output  32   PC of the instruction in flight / the halting HLT
//  dual_issue_active  output  1    always 0 (single-issue)
// BEHAVIOUR
//  - Instruction format:
//    - 2 bytes, big-endian: spec byte = mem_if_rdata[127:120], opcode = [119:112].
//    - Remaining fetch bytes are ignored.
//  - Opcodes:
//    - 0x00 NOP: PC += 2.
//    - 0x12 HLT: enter HALT; PC is not advanced.
//    - Spec byte is ignored for both.
//  - FSM with states FETCH, EXEC, HALT.
//  - Reset:
//    - state = FETCH, pc = RESET_PC; halted, mem_if_req and all data outputs = 0.
//    - Reset is honoured in every state, including mid-fetch and HALT; any outstanding request is abandoned.
//  - FETCH:
//    - mem_if_req = 1 and mem_if_addr = pc from the first cycle after rst deasserts.
//    - On mem_if_ack, latch rdata[127:112] into the instruction register and go to EXEC.
//    - mem_if_req is 0 in the EXEC cycle.
//  - EXEC (one cycle):
//    - NOP: pc <= pc + 2, then FETCH. Arithmetic is modulo 2^32, so 0xFFFF_FFFE wraps to 0.
//    - HLT: halted <= 1, then HALT.
//  - HALT:
//    - No further requests; pc frozen; halted stays 1 until rst.
//  - Acks and data:
//    - mem_if_ack while not in FETCH is ignored.
//    - mem_data_* inputs are ignored in all states.
//  - Latency:
//    - Memory latency is arbitrary (>= 1 cycle).
//    - With a 1-cycle ack, a NOP retires every 3 cycles (req, ack, exec).
//  - current_pc mirrors pc combinationally from the register. Address is not alignment-checked.
// CONFIGURATION
//  NEOCORE_ILLEGAL_HALT_EN
//    - Defined: an opcode other than 0x00/0x12 in EXEC sets halted = 1 and enters HALT, with current_pc at the offending instruction.
//    - Undefined: unknown opcodes execute as NOP (pc += 2).
// TESTING
//  1. Program NOP,NOP,HLT at 0x00/0x02/0x04 (bytes 00 00 00 00 00 12), rst 2 cycles, run 50 cycles
//     -> PC goes 0x00 -> 0x02 -> 0x04; halted = 1; current_pc = 0x04.
//  2. Memory word 0x00 = 00 12 -> halted within 5 cycles of reset release; current_pc = 0x00; mem_if_req stays 0 afterwards.
//  3. Reset held -> halted = 0, mem_if_req = 0, current_pc = RESET_PC, dual_issue_active = 0, mem_data_req = 0.
//  4. Assert rst during a fetch and after halt
//     -> next cycle halted = 0, pc = 0; execution restarts from 0x00.
//  5. Opcode 0x7F at 0x00, HLT at 0x02
//     -> without macro: halt at 0x02; with NEOCORE_ILLEGAL_HALT_EN: halt at 0x00.
//  6. Memory stub delays mem_if_ack by 4 cycles
//     -> mem_if_req and mem_if_addr held stable until ack; same final state as test 1.

Source files
------------

// File: rtl/neocore_core_top.sv
// NeoCore bring-up core: in-order, single-issue fetch/execute of NOP and HLT over a 128-bit fetch port.
// Optional NEOCORE_ILLEGAL_HALT_EN: unknown opcodes halt the core instead of executing as NOP.
module neocore_core_top #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_if_addr,
    output logic                  mem_if_req,
    input  logic [127:0]          mem_if_rdata,
    input  logic                  mem_if_ack,
    output logic [ADDR_WIDTH-1:0] mem_data_addr,
    output logic [31:0]           mem_data_wdata,
    output logic [1:0]            mem_data_size,
    output logic                  mem_data_we,
    output logic                  mem_data_req,
    input  logic [31:0]           mem_data_rdata,
    input  logic                  mem_data_ack,
    output logic                  halted,
    output logic [31:0]           current_pc,
    output logic                  dual_issue_active
);

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_HLT = 8'h12;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [15:0] r_ir;
    logic        r_req;
    logic        r_halted;
    logic [7:0]  w_opcode;
    logic        w_unused;

    assign w_opcode = r_ir[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= 16'h0000;
            r_req    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    // Only an ack answering our own request counts; the request drops in the EXEC cycle.
                    if (r_req && mem_if_ack) begin
                        r_ir    <= mem_if_rdata[127:112];
                        r_req   <= 1'b0;
                        r_state <= ST_EXEC;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (w_opcode)
                        OP_HLT: begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end
                        OP_NOP: begin
                            r_pc    <= r_pc + 32'd2;
                            r_req   <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                        default: begin
`ifdef NEOCORE_ILLEGAL_HALT_EN
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
`else
                            r_pc    <= r_pc + 32'd2;
                            r_req   <= 1'b1;
                            r_state <= ST_FETCH;
`endif
                        end
                    endcase
                end
                ST_HALT: begin
                    r_req <= 1'b0;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign mem_if_addr       = r_pc[ADDR_WIDTH-1:0];
    assign mem_if_req        = r_req;
    assign current_pc        = r_pc;
    assign halted            = r_halted;
    assign dual_issue_active = 1'b0;

    // Data port is reserved in this revision.
    assign mem_data_addr  = '0;
    assign mem_data_wdata = 32'h0000_0000;
    assign mem_data_size  = 2'b00;
    assign mem_data_we    = 1'b0;
    assign mem_data_req   = 1'b0;

    assign w_unused = ^{mem_if_rdata[111:0], mem_data_rdata, mem_data_ack, r_ir[15:8]};

endmodule

// File: tb/tb_neocore_core_top.sv
// Directed bench for neocore_core_top: fetch/exec/halt, reset cases, delayed acks and PC wrap.
module tb_neocore_core_top;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  mem_if_addr;
    logic         mem_if_req;
    logic [127:0] stub_rdata;
    logic         stub_ack;
    logic         extra_ack;
    logic         mem_if_ack;
    logic [31:0]  mem_data_addr;
    logic [31:0]  mem_data_wdata;
    logic [1:0]   mem_data_size;
    logic         mem_data_we;
    logic         mem_data_req;
    logic         halted;
    logic [31:0]  current_pc;
    logic         dual_issue_active;

    logic [31:0]  w_addr, w_daddr, w_dwdata, w_pc;
    logic [1:0]   w_dsize;
    logic         w_req, w_dwe, w_dreq, w_halted, w_dual, ack_w;
    logic [127:0] rdata_w;

    logic [7:0]   mem [256];
    int           lat = 1;
    int           cnt;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    assign mem_if_ack = stub_ack | extra_ack;

    neocore_core_top dut (
        .clk(clk), .rst(rst),
        .mem_if_addr(mem_if_addr), .mem_if_req(mem_if_req),
        .mem_if_rdata(stub_rdata), .mem_if_ack(mem_if_ack),
        .mem_data_addr(mem_data_addr), .mem_data_wdata(mem_data_wdata),
        .mem_data_size(mem_data_size), .mem_data_we(mem_data_we),
        .mem_data_req(mem_data_req), .mem_data_rdata(32'hDEAD_BEEF),
        .mem_data_ack(1'b1), .halted(halted), .current_pc(current_pc),
        .dual_issue_active(dual_issue_active)
    );

    // Second core starts two bytes below the 32-bit wrap point.
    neocore_core_top #(.RESET_PC(32'hFFFF_FFFE)) dut_wrap (
        .clk(clk), .rst(rst),
        .mem_if_addr(w_addr), .mem_if_req(w_req),
        .mem_if_rdata(rdata_w), .mem_if_ack(ack_w),
        .mem_data_addr(w_daddr), .mem_data_wdata(w_dwdata),
        .mem_data_size(w_dsize), .mem_data_we(w_dwe),
        .mem_data_req(w_dreq), .mem_data_rdata(32'h0),
        .mem_data_ack(1'b0), .halted(w_halted), .current_pc(w_pc),
        .dual_issue_active(w_dual)
    );

    assign rdata_w = (w_addr == 32'h2) ? {8'h00, 8'h12, 112'h0} : 128'h0;

    always @(posedge clk) ack_w <= !rst && w_req && !ack_w;

    function automatic logic [127:0] fetch16(input logic [31:0] a);
        logic [127:0] r;
        logic [7:0]   idx;
        for (int i = 0; i < 16; i++) begin
            idx = a[7:0] + 8'(i);
            r[127-8*i -: 8] = mem[idx];
        end
        return r;
    endfunction

    // Memory stub: acks a held request after `lat` cycles with a one-cycle pulse.
    always @(posedge clk) begin
        stub_ack <= 1'b0;
        if (rst) begin
            cnt <= 0;
        end else if (mem_if_req && !stub_ack) begin
            if (cnt + 1 >= lat) begin
                stub_ack   <= 1'b1;
                stub_rdata <= fetch16(mem_if_addr);
                cnt        <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin
        logic [31:0] seen[$];
        logic [31:0] a0;
        logic        req_seen, stable;
        int          cyc, t2, n;
        logic [31:0] exp_pc5;

        extra_ack = 1'b0;
        @(negedge clk);

        // Test 1: NOP, NOP, HLT with single-cycle acks.
        clear_mem();
        mem[5] = 8'h12;
        lat = 1;
        apply_reset(2);
        seen.push_back(current_pc);
        cyc = 0;
        t2 = 0;
        while (!halted && cyc < 50) begin
            tick();
            cyc++;
            if (current_pc !== seen[$]) begin
                seen.push_back(current_pc);
                if (current_pc == 32'h2 && t2 == 0) t2 = cyc;
            end
        end
        chk("t1_pc_steps", seen.size(), 3);
        chk("t1_pc0", seen[0], 32'h0);
        chk("t1_pc1", seen[1], 32'h2);
        chk("t1_pc2", seen[2], 32'h4);
        chk("t1_nop_retire_cycle", t2, 4);
        chk("t1_halt_cycle", cyc, 10);
        chk("t1_halted", halted, 1);
        chk("t1_current_pc", current_pc, 32'h4);
        chk("wrap_halted", w_halted, 1);
        chk("wrap_pc", w_pc, 32'h2);

        // Test 2: HLT at 0x00, then stray ack and quiet bus while halted.
        clear_mem();
        mem[1] = 8'h12;
        apply_reset(2);
        run_to_halt(20, cyc);
        chk("t2_halted", halted, 1);
        chk("t2_latency_le5", 32'(cyc <= 5), 1);
        chk("t2_current_pc", current_pc, 32'h0);
        extra_ack = 1'b1;
        tick();
        extra_ack = 1'b0;
        req_seen = 1'b0;
        repeat (10) begin
            tick();
            req_seen = req_seen | mem_if_req;
        end
        chk("t2_req_quiet", req_seen, 0);
        chk("t2_still_halted", halted, 1);
        chk("t2_pc_frozen", current_pc, 32'h0);

        // Test 3: reset held (also clears a halted core).
        rst = 1'b1;
        repeat (3) tick();
        chk("t3_halted", halted, 0);
        chk("t3_req", mem_if_req, 0);
        chk("t3_pc", current_pc, 32'h0);
        chk("t3_dual", dual_issue_active, 0);
        chk("t3_data_req", mem_data_req, 0);
        chk("t3_data_we", mem_data_we, 0);
        chk("t3_data_addr", mem_data_addr, 32'h0);
        chk("t3_data_wdata", mem_data_wdata, 32'h0);
        chk("t3_data_size", mem_data_size, 0);
        chk("t3_wrap_reset_pc", w_pc, 32'hFFFF_FFFE);

        // Test 4: reset mid-fetch, restart, then reset after halt.
        clear_mem();
        mem[5] = 8'h12;
        rst = 1'b0;
        n = 0;
        while (!(current_pc == 32'h2 && mem_if_req) && n < 20) begin
            tick();
            n++;
        end
        chk("t4_reached_fetch", {current_pc[30:0], mem_if_req}, {31'h2, 1'b1});
        rst = 1'b1;
        tick();
        chk("t4_rst_halted", halted, 0);
        chk("t4_rst_pc", current_pc, 32'h0);
        chk("t4_rst_req", mem_if_req, 0);
        rst = 1'b0;
        tick();
        chk("t4_restart_req", mem_if_req, 1);
        chk("t4_restart_addr", mem_if_addr, 32'h0);
        run_to_halt(50, cyc);
        chk("t4_halted", halted, 1);
        chk("t4_current_pc", current_pc, 32'h4);
        rst = 1'b1;
        tick();
        chk("t4_halt_rst_halted", halted, 0);
        chk("t4_halt_rst_pc", current_pc, 32'h0);

        // Test 5: unknown opcode 0x7F at 0x00, HLT at 0x02.
        clear_mem();
        mem[1] = 8'h7F;
        mem[3] = 8'h12;
        apply_reset(2);
        run_to_halt(50, cyc);
`ifdef NEOCORE_ILLEGAL_HALT_EN
        exp_pc5 = 32'h0;
`else
        exp_pc5 = 32'h2;
`endif
        chk("t5_halted", halted, 1);
        chk("t5_current_pc", current_pc, exp_pc5);

        // Test 6: four-cycle ack latency.
        clear_mem();
        mem[5] = 8'h12;
        lat = 4;
        apply_reset(2);
        tick();
        a0 = mem_if_addr;
        stable = 1'b1;
        n = 0;
        while (!stub_ack && n < 20) begin
            if (!mem_if_req || mem_if_addr !== a0) stable = 1'b0;
            tick();
            n++;
        end
        chk("t6_req_addr_stable", stable, 1);
        chk("t6_ack_delay", n, 4);
        chk("t6_req_in_ack_cycle", mem_if_req, 1);
        run_to_halt(200, cyc);
        chk("t6_halted", halted, 1);
        chk("t6_current_pc", current_pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
